alu_share_arbiter: RTL

Shares one instance of the 4-bit combinational ALU (add/sub/not/and/or/xor/less-than/equal) between NREQ independent requesters. Uses per-requester valid/ready command and response channels, round-robin arbitration and registered results. Sits between requesting sequencers and the single ALU, so the ALU never sees more than one operation at a time.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu4.sv | 46 ++++
 rtl/rr_pick.sv | 29 ++
 rtl/alu_share_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and datapath width for the shared-ALU arbiter
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu4.sv
// rtl/alu4.sv - 4-bit combinational ALU: add/sub/not/and/or/xor/unsigned less-than/equal
module alu4
  import alu_pkg::*;
(
  input  logic [2:0]       op_i,
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  output logic [ALU_W-1:0] s_o,
  output logic             c_o,
  output logic             out_o,
  output logic             ovf_o
);

  logic [ALU_W:0] wide;

  always_comb begin
    s_o   = '0;
    c_o   = 1'b0;
    out_o = 1'b0;
    ovf_o = 1'b0;
    wide  = '0;
    case (op_i)
      OP_ADD: begin
        wide  = {1'b0, a_i} + {1'b0, b_i};
        s_o   = wide[ALU_W-1:0];
        c_o   = wide[ALU_W];
        ovf_o = (a_i[ALU_W-1] == b_i[ALU_W-1]) && (s_o[ALU_W-1] != a_i[ALU_W-1]);
      end
      OP_SUB: begin
        // c_o is the borrow: set when a < b unsigned
        wide  = {1'b0, a_i} - {1'b0, b_i};
        s_o   = wide[ALU_W-1:0];
        c_o   = wide[ALU_W];
        ovf_o = (a_i[ALU_W-1] != b_i[ALU_W-1]) && (s_o[ALU_W-1] != a_i[ALU_W-1]);
      end
      OP_NOT:  s_o   = ~a_i;
      OP_AND:  s_o   = a_i & b_i;
      OP_OR:   s_o   = a_i | b_i;
      OP_XOR:  s_o   = a_i ^ b_i;
      OP_LT:   out_o = (a_i < b_i);
      OP_EQ:   out_o = (a_i == b_i);
      default: s_o   = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector searching upward from last_i+1
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_i) + k) % NREQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one 4-bit ALU among NREQ requesters
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_opcode,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [ALU_W-1:0]      rsp_s,
  output logic                  rsp_c,
  output logic                  rsp_out,
  output logic                  rsp_ovf,
  output logic                  busy
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [ALU_W-1:0] a_q, b_q;
  logic [IW-1:0]    cur_id_q, last_q;
  logic [ALU_W-1:0] res_s_q;
  logic             res_c_q, res_out_q, res_ovf_q;

  logic [NREQ-1:0]  gnt;
  logic [IW-1:0]    win_idx;
  logic             any_req;
  logic [ALU_W-1:0] alu_s;
  logic             alu_c, alu_out, alu_ovf;
  logic             accept, done;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (win_idx),
    .any_o  (any_req)
  );

  alu4 u_alu (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .s_o   (alu_s),
    .c_o   (alu_c),
    .out_o (alu_out),
    .ovf_o (alu_ovf)
  );

  assign accept  = (state_q == S_IDLE) && any_req;
  assign done    = (state_q == S_RESP) && rsp_ready[cur_id_q];
  assign busy    = (state_q != S_IDLE);
  assign rsp_s   = res_s_q;
  assign rsp_c   = res_c_q;
  assign rsp_out = res_out_q;
  assign rsp_ovf = res_ovf_q;

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      S_IDLE: begin
        // Gated by rst_n so no requester sees ready while reset is held
        if (rst_n) req_ready = gnt;
        if (any_req) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        rsp_valid[cur_id_q] = 1'b1;
        if (rsp_ready[cur_id_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cur_id_q  <= '0;
      last_q    <= IW'(NREQ - 1);
      res_s_q   <= '0;
      res_c_q   <= 1'b0;
      res_out_q <= 1'b0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= req_opcode[3*int'(win_idx) +: 3];
        a_q      <= req_a[ALU_W*int'(win_idx) +: ALU_W];
        b_q      <= req_b[ALU_W*int'(win_idx) +: ALU_W];
        cur_id_q <= win_idx;
      end
      if (state_q == S_EXEC) begin
        res_s_q   <= alu_s;
        res_c_q   <= alu_c;
        res_out_q <= alu_out;
        res_ovf_q <= alu_ovf;
      end
      if (done) last_q <= cur_id_q;
    end
  end

endmodule
